memory_port_arbiter: RTL and testbench

//  Shares the single Memory block (ROM below 2^ROM_ADDR_BITS, RAM above) between the

---
 rtl/memory_port_arbiter_if.sv | 36 +++
 rtl/memory_port_arbiter.sv | 131 +++++++++++++
 tb/tb_memory_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_port_arbiter_if.sv
// Bundles the fetch port, data port and Memory-side bus that the arbiter sits between.
// Arbiter side uses modport slave; requesters and the Memory model use modport master.
interface memory_port_arbiter_if;
    logic        ifReq;
    logic [31:0] ifAddress;
    logic        ifDone;
    logic [31:0] ifData;

    logic        dmReq;
    logic        dmWrite;
    logic [31:0] dmAddress;
    logic [31:0] dmWriteData;
    logic        dmDone;
    logic [31:0] dmReadData;
    logic        dmFault;

    logic [31:0] memAddress;
    logic        memWriteEnable;
    logic        memReadEnable;
    logic [31:0] memDataIn;
    logic [31:0] memDataOut;

    logic        busy;

    modport slave (
        input  ifReq, ifAddress, dmReq, dmWrite, dmAddress, dmWriteData, memDataOut,
        output ifDone, ifData, dmDone, dmReadData, dmFault,
               memAddress, memWriteEnable, memReadEnable, memDataIn, busy
    );

    modport master (
        output ifReq, ifAddress, dmReq, dmWrite, dmAddress, dmWriteData, memDataOut,
        input  ifDone, ifData, dmDone, dmReadData, dmFault,
               memAddress, memWriteEnable, memReadEnable, memDataIn, busy
    );
endinterface

// File: rtl/memory_port_arbiter.sv
// Shares one Memory between fetch and data ports; stores to ROM fault. Option: ARBITER_ROUND_ROBIN_EN.
// Latency: done pulse MEM_LATENCY+1 cycles after grant (1 cycle for a ROM-write fault).
// Backpressure: requests are level-held until done; a losing or late request waits in IDLE.
module memory_port_arbiter #(
    parameter int MEM_LATENCY   = 1,
    parameter int ROM_ADDR_BITS = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    memory_port_arbiter_if.slave  bus
);
    localparam int            CW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state;
    state_t        stateNext;
    logic [CW-1:0] cnt;
    logic          winDm;
    logic          latWrite;
    logic          fault;
    logic          lastGrantDm;
    logic [31:0]   latAddr;
    logic [31:0]   latWdata;
    logic [31:0]   ifDataQ;
    logic [31:0]   dmDataQ;
    logic          grantAny;
    logic          grantDm;
    logic          preferDm;
    logic          romWrite;

    always_comb begin
`ifdef ARBITER_ROUND_ROBIN_EN
        preferDm = ~lastGrantDm;
`else
        // Grant history is still tracked, but fixed priority always favours DM.
        preferDm = lastGrantDm | 1'b1;
`endif
        grantAny = bus.ifReq | bus.dmReq;
        grantDm  = bus.dmReq & (~bus.ifReq | preferDm);
        romWrite = grantDm & bus.dmWrite & (bus.dmAddress[31:ROM_ADDR_BITS] == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext          = state;
        bus.memAddress     = '0;
        bus.memReadEnable  = 1'b0;
        bus.memWriteEnable = 1'b0;
        bus.memDataIn      = '0;
        bus.ifDone         = 1'b0;
        bus.dmDone         = 1'b0;
        bus.dmFault        = 1'b0;
        unique case (state)
            IDLE: begin
                if (grantAny) begin
                    stateNext = romWrite ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                bus.memAddress     = latAddr;
                bus.memReadEnable  = ~latWrite;
                bus.memDataIn      = latWdata;
                // Only the first ACCESS cycle writes, so a long latency never repeats a store.
                bus.memWriteEnable = latWrite & (cnt == CNT_LOAD);
                if (cnt == '0) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                bus.ifDone  = ~winDm;
                bus.dmDone  = winDm;
                bus.dmFault = winDm & fault;
                stateNext   = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            winDm       <= 1'b0;
            latWrite    <= 1'b0;
            latAddr     <= '0;
            latWdata    <= '0;
            fault       <= 1'b0;
            lastGrantDm <= 1'b0;
            ifDataQ     <= '0;
            dmDataQ     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grantAny) begin
                        winDm       <= grantDm;
                        lastGrantDm <= grantDm;
                        latWrite    <= grantDm & bus.dmWrite;
                        latAddr     <= grantDm ? bus.dmAddress : bus.ifAddress;
                        latWdata    <= grantDm ? bus.dmWriteData : '0;
                        fault       <= romWrite;
                        cnt         <= CNT_LOAD;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        if (!winDm) begin
                            ifDataQ <= bus.memDataOut;
                        end else if (!latWrite) begin
                            dmDataQ <= bus.memDataOut;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ifData     = ifDataQ;
    assign bus.dmReadData = dmDataQ;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_memory_port_arbiter.sv
// Randomized and directed bench for memory_port_arbiter against a transaction-level model.
// The model schedules each grant in plain cycle arithmetic and tracks memory contents in a map.
module tb_memory_port_arbiter;
    localparam int LAT = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } req_t;

    logic clk;
    logic reset;
    memory_port_arbiter_if bus();

    memory_port_arbiter #(.MEM_LATENCY(LAT), .ROM_ADDR_BITS(11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem    [logic [31:0]];
    logic [31:0] refMem [logic [31:0]];

    function automatic logic [31:0] defWord(input logic [31:0] a);
        return a * 32'h9E37_79B1;
    endfunction

    function automatic logic [31:0] memRd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : defWord(a);
    endfunction

    function automatic logic [31:0] refRd(input logic [31:0] a);
        return refMem.exists(a) ? refMem[a] : defWord(a);
    endfunction

    // Memory model: combinational-style read refreshed each cycle, write on the enable pulse.
    always @(negedge clk) begin
        if (bus.memWriteEnable) mem[bus.memAddress] = bus.memDataIn;
        bus.memDataOut = bus.memReadEnable ? memRd(bus.memAddress) : 32'h0;
    end

    int    checks = 0;
    int    failures = 0;
    int    cyc;
    int    freeAt;
    int    wePulses;
    int    faultSeen;
    int    ifIssueCyc, ifDoneCyc, dmIssueCyc, dmDoneCyc;
    bit    gapEn;
    string doneLog;

    req_t  ifQ[$];
    req_t  dmQ[$];
    req_t  ifCur, dmCur;
    bit    ifAct, dmAct;

    bit          mValid, mDm, mFault, mLastDm;
    int          mGrantCyc, mDoneCyc;
    req_t        mReq;
    logic [31:0] mData;
    logic [31:0] expIfData, expDmData;

    function automatic req_t mkReq(input logic [31:0] a, input logic w, input logic [31:0] d);
        req_t r;
        r.addr = a; r.write = w; r.wdata = d;
        return r;
    endfunction

    task automatic resetModel();
        mValid = 0; mLastDm = 0; freeAt = 0; cyc = 0;
        expIfData = 32'h0; expDmData = 32'h0;
        ifAct = 0; dmAct = 0; ifQ.delete(); dmQ.delete();
        bus.ifReq = 1'b0; bus.dmReq = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1; bus.ifReq = 1'b0; bus.dmReq = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        resetModel();
    endtask

    // One cycle: compare DUT against the model, react to done pulses, issue requests, schedule grants.
    task automatic step();
        logic        inAcc, eIfDone, eDmDone;
        logic [5:0]  eCtl, aCtl;
        logic [31:0] eAddr, eDin;
        bit          wDm;
        @(negedge clk);
        inAcc   = mValid && !mFault && (cyc > mGrantCyc) && (cyc <= mGrantCyc + LAT);
        eIfDone = mValid && !mDm && (cyc == mDoneCyc);
        eDmDone = mValid && mDm && (cyc == mDoneCyc);
        if (eIfDone) expIfData = mData;
        if (eDmDone && !mReq.write) expDmData = mData;
        eCtl  = {cyc < freeAt, eIfDone, eDmDone, eDmDone && mFault,
                 inAcc && !mReq.write, inAcc && mReq.write && (cyc == mGrantCyc + 1)};
        aCtl  = {bus.busy, bus.ifDone, bus.dmDone, bus.dmFault, bus.memReadEnable, bus.memWriteEnable};
        eAddr = inAcc ? mReq.addr : 32'h0;
        eDin  = inAcc ? mReq.wdata : 32'h0;

        checks++;
        if (aCtl !== eCtl) begin failures++;
            $display("FAIL ctl cyc=%0d {busy,ifDone,dmDone,dmFault,re,we} got=%b exp=%b", cyc, aCtl, eCtl); end
        checks++;
        if (bus.memAddress !== eAddr) begin failures++;
            $display("FAIL memAddress cyc=%0d got=%h exp=%h", cyc, bus.memAddress, eAddr); end
        checks++;
        if (bus.memDataIn !== eDin) begin failures++;
            $display("FAIL memDataIn cyc=%0d got=%h exp=%h", cyc, bus.memDataIn, eDin); end
        checks++;
        if (bus.ifData !== expIfData) begin failures++;
            $display("FAIL ifData cyc=%0d got=%h exp=%h", cyc, bus.ifData, expIfData); end
        checks++;
        if (bus.dmReadData !== expDmData) begin failures++;
            $display("FAIL dmReadData cyc=%0d got=%h exp=%h", cyc, bus.dmReadData, expDmData); end

        if (bus.memWriteEnable === 1'b1) wePulses++;
        if (bus.dmFault === 1'b1) faultSeen++;
        if (bus.ifDone === 1'b1) begin
            ifAct = 0; bus.ifReq = 1'b0; ifDoneCyc = cyc; doneLog = {doneLog, "I"};
        end
        if (bus.dmDone === 1'b1) begin
            dmAct = 0; bus.dmReq = 1'b0; dmDoneCyc = cyc; doneLog = {doneLog, "D"};
        end
        if (mValid && cyc == mDoneCyc) mValid = 0;

        if (!ifAct && ifQ.size() > 0 && (!gapEn || $urandom_range(0, 2) != 0)) begin
            ifCur = ifQ.pop_front(); ifAct = 1; ifIssueCyc = cyc;
            bus.ifReq = 1'b1; bus.ifAddress = ifCur.addr;
        end
        if (!dmAct && dmQ.size() > 0 && (!gapEn || $urandom_range(0, 2) != 0)) begin
            dmCur = dmQ.pop_front(); dmAct = 1; dmIssueCyc = cyc;
            bus.dmReq = 1'b1; bus.dmWrite = dmCur.write;
            bus.dmAddress = dmCur.addr; bus.dmWriteData = dmCur.wdata;
        end

        if (!mValid && cyc >= freeAt && (bus.ifReq || bus.dmReq)) begin
`ifdef ARBITER_ROUND_ROBIN_EN
            wDm = bus.dmReq && (!bus.ifReq || !mLastDm);
`else
            wDm = bus.dmReq;
`endif
            mDm       = wDm;
            mReq      = wDm ? dmCur : ifCur;
            mFault    = wDm && mReq.write && (mReq.addr < 32'd2048);
            mGrantCyc = cyc;
            mDoneCyc  = cyc + (mFault ? 1 : LAT + 1);
            freeAt    = mDoneCyc + 1;
            mData     = refRd(mReq.addr);
            if (mReq.write && !mFault) refMem[mReq.addr] = mReq.wdata;
            mLastDm   = wDm;
            mValid    = 1;
        end
        cyc++;
    endtask

    task automatic runUntilIdle(input int budget, input string name);
        int n;
        n = 0;
        while ((ifQ.size() > 0 || dmQ.size() > 0 || ifAct || dmAct || mValid) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s timeout got=still-busy after %0d cycles exp=idle", name, budget);
            doReset();
        end
    endtask

    task automatic test_reset();
        logic [101:0] outs;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            outs = {bus.busy, bus.ifDone, bus.dmDone, bus.dmFault, bus.memReadEnable, bus.memWriteEnable,
                    bus.ifData, bus.dmReadData, bus.memAddress[5:0]} | {96'h0, bus.memDataIn[5:0]};
            checks++;
            if (outs !== '0 || bus.memAddress !== 32'h0 || bus.memDataIn !== 32'h0) begin failures++;
                $display("FAIL reset_outputs cycle=%0d got=%h exp=0", i, outs); end
        end
        bus.ifReq = 1'b0; bus.dmReq = 1'b0;
        reset = 1'b0;
        resetModel();
    endtask

    task automatic test_if_fetch();
        wePulses = 0;
        ifQ.push_back(mkReq(32'h0000_0010, 1'b0, 32'h0));
        runUntilIdle(50, "if_fetch");
        checks++;
        if (bus.ifData !== 32'hDEAD_BEEF) begin failures++;
            $display("FAIL if_fetch_data got=%h exp=deadbeef", bus.ifData); end
        checks++;
        if (ifDoneCyc - ifIssueCyc != LAT + 1) begin failures++;
            $display("FAIL if_fetch_latency got=%0d exp=%0d", ifDoneCyc - ifIssueCyc, LAT + 1); end
        checks++;
        if (wePulses != 0) begin failures++;
            $display("FAIL if_fetch_no_write got=%0d exp=0", wePulses); end
    endtask

    task automatic test_store_load();
        wePulses = 0; faultSeen = 0;
        dmQ.push_back(mkReq(32'h0000_1000, 1'b1, 32'h1234_5678));
        dmQ.push_back(mkReq(32'h0000_1000, 1'b0, $urandom));
        runUntilIdle(50, "store_load");
        checks++;
        if (wePulses != 1) begin failures++;
            $display("FAIL store_write_pulses got=%0d exp=1", wePulses); end
        checks++;
        if (bus.dmReadData !== 32'h1234_5678) begin failures++;
            $display("FAIL load_after_store got=%h exp=12345678", bus.dmReadData); end
        checks++;
        if (faultSeen != 0 || memRd(32'h1000) !== 32'h1234_5678) begin failures++;
            $display("FAIL store_ram got=fault%0d/%h exp=fault0/12345678", faultSeen, memRd(32'h1000)); end
    endtask

    task automatic test_rom_fault();
        wePulses = 0; faultSeen = 0;
        dmQ.push_back(mkReq(32'h0000_0004, 1'b1, 32'hCAFE_F00D));
        runUntilIdle(50, "rom_fault");
        checks++;
        if (faultSeen != 1) begin failures++;
            $display("FAIL rom_fault_flag got=%0d exp=1", faultSeen); end
        checks++;
        if (dmDoneCyc - dmIssueCyc != 1) begin failures++;
            $display("FAIL rom_fault_latency got=%0d exp=1", dmDoneCyc - dmIssueCyc); end
        checks++;
        if (wePulses != 0 || memRd(32'h4) !== 32'h0BAD_F00D) begin failures++;
            $display("FAIL rom_unchanged got=we%0d/%h exp=we0/0badf00d", wePulses, memRd(32'h4)); end
        checks++;
        if (bus.dmReadData !== 32'h1234_5678) begin failures++;
            $display("FAIL fault_keeps_readdata got=%h exp=12345678", bus.dmReadData); end
    endtask

    task automatic test_contention();
        string expLog;
        doReset();
        doneLog = ""; gapEn = 0;
        for (int i = 0; i < 3; i++) begin
            dmQ.push_back(mkReq(32'h0000_1000 + 32'(4 * i), 1'b0, $urandom));
            ifQ.push_back(mkReq(32'h0000_0020 + 32'(4 * i), 1'b0, 32'h0));
        end
        runUntilIdle(100, "contention");
`ifdef ARBITER_ROUND_ROBIN_EN
        expLog = "DIDIDI";
`else
        expLog = "DDDIII";
`endif
        checks++;
        if (doneLog != expLog) begin failures++;
            $display("FAIL contention_order got=%s exp=%s", doneLog, expLog); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        doneLog = ""; gapEn = 1;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 1) == 0) ? 32'(4 * $urandom_range(0, 7)) : 32'h1000 + 32'(4 * $urandom_range(0, 7));
            dmQ.push_back(mkReq(a, 1'($urandom_range(0, 1)), $urandom));
            a = ($urandom_range(0, 1) == 0) ? 32'(4 * $urandom_range(0, 7)) : 32'h1000 + 32'(4 * $urandom_range(0, 7));
            ifQ.push_back(mkReq(a, 1'b0, 32'h0));
        end
        runUntilIdle(6000, "random");
        checks++;
        if (doneLog.len() != 80) begin failures++;
            $display("FAIL random_done_count got=%0d exp=80", doneLog.len()); end
        gapEn = 0;
    endtask

    task automatic test_reset_mid_access();
        int n;
        n = 0;
        ifQ.push_back(mkReq(32'h0000_1008, 1'b0, 32'h0));
        while (!(mValid && cyc == mGrantCyc + 2) && n < 20) begin step(); n++; end
        checks++;
        if (n >= 20) begin failures++;
            $display("FAIL reset_mid_setup got=no-grant exp=access-in-progress"); end
        reset = 1'b1; bus.ifReq = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.ifDone, bus.dmDone, bus.memReadEnable, bus.memWriteEnable} !== 5'b0 ||
            bus.memAddress !== 32'h0 || bus.ifData !== 32'h0) begin failures++;
            $display("FAIL reset_mid_access got=busy%b done%b re%b addr=%h ifData=%h exp=all-zero",
                     bus.busy, bus.ifDone, bus.memReadEnable, bus.memAddress, bus.ifData); end
        reset = 1'b0;
        resetModel();
        repeat (LAT + 3) step();
    endtask

    initial begin
        reset = 1'b1;
        bus.ifReq = 1'b1; bus.ifAddress = 32'h0000_0010;
        bus.dmReq = 1'b1; bus.dmWrite = 1'b1; bus.dmAddress = 32'h0000_1000; bus.dmWriteData = 32'hFFFF_FFFF;
        gapEn = 0; doneLog = "";
        ifIssueCyc = 0; ifDoneCyc = 0; dmIssueCyc = 0; dmDoneCyc = 0;
        mem[32'h10] = 32'hDEAD_BEEF;    refMem[32'h10] = 32'hDEAD_BEEF;
        mem[32'h4]  = 32'h0BAD_F00D;    refMem[32'h4]  = 32'h0BAD_F00D;
        test_reset();
        test_if_fetch();
        test_store_load();
        test_rom_fault();
        test_contention();
        test_random();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
